// File: rtl/issue_buffer_pkg.sv
// Shared widths, pipeline-mask bit positions and slot-release helper for the issue buffer.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif
`ifndef PIPE_REG_PC
`define PIPE_REG_PC 0
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 1
`endif
`ifndef ISSUE_BUF_DEPTH
`define ISSUE_BUF_DEPTH 8
`endif

package issue_buffer_pkg;
  localparam int INST_W    = `INST_WIDTH;
  localparam int MASK_W    = `NUM_PIPE_MASKS;
  localparam int IF_ID_BIT = `PIPE_REG_IF_ID;

  typedef enum logic [1:0] {
    RET_NONE = 2'd0,
    RET_ONE  = 2'd1,
    RET_TWO  = 2'd2
  } retire_e;

  // A slot leaves the buffer only when it holds an entry and IF/ID is not stalled for it.
  function automatic logic slot_released(input logic valid, input logic [MASK_W-1:0] mask);
    return valid && !mask[IF_ID_BIT];
  endfunction
endpackage

// File: rtl/issue_buffer_ram.sv
// Register array for the issue buffer: one aligned pair-write port, two async read ports.
module issue_buffer_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata0,
  input  logic [WIDTH-1:0]         wdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr0,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output logic [WIDTH-1:0]         rdata0,
  output logic [WIDTH-1:0]         rdata1
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // waddr is always even, so the pair occupies waddr and waddr|1.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr]            <= wdata0;
      mem_q[waddr | AW'(1)]   <= wdata1;
    end
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];
endmodule

// File: rtl/issue_buffer.sv
// Dual-issue instruction queue: pair pushes from fetch, oldest two entries presented by index parity.
`ifndef ISSUE_BUF_DEPTH
`define ISSUE_BUF_DEPTH 8
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif

module issue_buffer
  import issue_buffer_pkg::*;
#(
  parameter int DEPTH    = `ISSUE_BUF_DEPTH,
  parameter int PC_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_valid,
  input  logic [`INST_WIDTH-1:0]     fetch_inst0,
  input  logic [`INST_WIDTH-1:0]     fetch_inst1,
  input  logic [PC_WIDTH-1:0]        fetch_pc,
  output logic                       fetch_ready,
  input  logic                       branch_flush,
  input  logic [`NUM_PIPE_MASKS-1:0] stall0,
  input  logic [`NUM_PIPE_MASKS-1:0] stall1,
  output logic [`INST_WIDTH-1:0]     instruction0,
  output logic [`INST_WIDTH-1:0]     instruction1,
  output logic [PC_WIDTH-1:0]        pc0,
  output logic [PC_WIDTH-1:0]        pc1,
  output logic                       valid0,
  output logic                       valid1,
  output logic                       first,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       order_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = INST_W + PC_WIDTH;

  logic [AW-1:0] head_q, head_d, tail_q, tail_d, young_idx;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] old_e, young_e, slot0_e, slot1_e;
  logic          valid_old, valid_young, rel_old, rel_young, push;
  logic [MASK_W-1:0] stall_old, stall_young;
  retire_e       retire;

  assign young_idx = head_q + AW'(1);

  issue_buffer_ram #(.DEPTH(DEPTH), .WIDTH(EW)) u_ram (
    .clk    (clk),
    .we     (push),
    .waddr  (tail_q),
    .wdata0 ({fetch_inst0, fetch_pc}),
    .wdata1 ({fetch_inst1, fetch_pc + PC_WIDTH'(1)}),
    .raddr0 (head_q),
    .raddr1 (young_idx),
    .rdata0 (old_e),
    .rdata1 (young_e)
  );

  // Even indices live in slot1, odd in slot0; an even head means slot1 is older.
  always_comb begin
    first       = ~head_q[0];
    valid_old   = (count_q != '0);
    valid_young = (count_q >= CW'(2));
    valid0      = first ? valid_young : valid_old;
    valid1      = first ? valid_old : valid_young;
    slot0_e     = first ? young_e : old_e;
    slot1_e     = first ? old_e : young_e;
    instruction0 = valid0 ? slot0_e[EW-1:PC_WIDTH] : '0;
    pc0          = valid0 ? slot0_e[PC_WIDTH-1:0] : '0;
    instruction1 = valid1 ? slot1_e[EW-1:PC_WIDTH] : '0;
    pc1          = valid1 ? slot1_e[PC_WIDTH-1:0] : '0;
    count        = count_q;
  end

  always_comb begin
    stall_old   = first ? stall1 : stall0;
    stall_young = first ? stall0 : stall1;
    rel_old     = slot_released(valid_old, stall_old);
    rel_young   = slot_released(valid_young, stall_young);
    retire      = RET_NONE;
    if (rel_old) retire = rel_young ? RET_TWO : RET_ONE;
    order_err   = rel_young && !rel_old && !reset && !branch_flush;
    fetch_ready = (count_q <= CW'(DEPTH - 2));
    push        = fetch_valid && fetch_ready && !reset && !branch_flush;
  end

  always_comb begin
    head_d  = head_q + AW'(retire);
    tail_d  = tail_q + AW'({push, 1'b0});
    count_d = count_q + CW'({push, 1'b0}) - CW'(retire);
    if (reset || branch_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end
endmodule

// File: tb/tb_issue_buffer.sv
// Directed bench for issue_buffer: pair push/visibility, partial retire, full, wrap, flush, order error.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif

module tb_issue_buffer;
  localparam int PC_WIDTH = 16;
  localparam logic [4:0] HOLD = 5'b00011;  // PC | IF_ID
  localparam logic [4:0] PCM  = 5'b00001;  // PC only
  localparam logic [4:0] GO   = 5'b00000;

  logic clk = 1'b0;
  logic reset, fetch_valid, branch_flush, fetch_ready;
  logic [`INST_WIDTH-1:0] fetch_inst0, fetch_inst1, instruction0, instruction1;
  logic [PC_WIDTH-1:0] fetch_pc, pc0, pc1;
  logic [`NUM_PIPE_MASKS-1:0] stall0, stall1;
  logic valid0, valid1, first, order_err;
  logic [3:0] count;

  int n_cmp = 0;
  int n_err = 0;

  issue_buffer #(.DEPTH(8), .PC_WIDTH(PC_WIDTH)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid),
    .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .branch_flush(branch_flush),
    .stall0(stall0), .stall1(stall1),
    .instruction0(instruction0), .instruction1(instruction1),
    .pc0(pc0), .pc1(pc1), .valid0(valid0), .valid1(valid1),
    .first(first), .count(count), .order_err(order_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; checks happen after the #1 settle as well.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fv, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [15:0] pc, input logic fl,
                       input logic [4:0] s0, input logic [4:0] s1);
    fetch_valid  = fv;
    fetch_inst0  = i0;
    fetch_inst1  = i1;
    fetch_pc     = pc;
    branch_flush = fl;
    stall0       = s0;
    stall1       = s1;
    #1;
  endtask

  task automatic chk_slots(input string tag, input logic [31:0] i0, input logic [15:0] p0,
                           input logic [31:0] i1, input logic [15:0] p1);
    chk({tag, "_inst0"}, 64'(instruction0), 64'(i0));
    chk({tag, "_pc0"},   64'(pc0),          64'(p0));
    chk({tag, "_inst1"}, 64'(instruction1), 64'(i1));
    chk({tag, "_pc1"},   64'(pc1),          64'(p1));
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, GO, GO);
    tick(); tick();
    reset = 1'b0;
    #1;
    // 1. reset state
    chk("rst_valid0", 64'(valid0), 64'(0));
    chk("rst_valid1", 64'(valid1), 64'(0));
    chk("rst_first",  64'(first),  64'(1));
    chk("rst_count",  64'(count),  64'(0));
    chk("rst_ready",  64'(fetch_ready), 64'(1));
    chk("rst_oerr",   64'(order_err),   64'(0));
    chk_slots("rst", 32'h0, 16'h0, 32'h0, 16'h0);

    // 2. push A0/A1 at pc 0x10, no stalls
    drive(1, 32'hA0A0_0000, 32'hA1A1_0001, 16'h0010, 0, GO, GO);
    tick();
    drive(0, 0, 0, 0, 0, GO, GO);
    chk_slots("pair", 32'hA1A1_0001, 16'h0011, 32'hA0A0_0000, 16'h0010);
    chk("pair_first", 64'(first), 64'(1));
    chk("pair_count", 64'(count), 64'(2));
    chk("pair_v0v1",  64'({valid0, valid1}), 64'(2'b11));
    tick();
    chk("pair_retire_count", 64'(count), 64'(0));
    chk("pair_retire_v0", 64'(valid0), 64'(0));

    // 3. four entries at head=2; older released, younger held -> retire 1
    drive(1, 32'hA0A0_0000, 32'hA1A1_0001, 16'h0020, 0, HOLD, HOLD);
    tick();
    drive(1, 32'hA2A2_0002, 32'hA3A3_0003, 16'h0022, 0, HOLD, HOLD);
    tick();
    drive(0, 0, 0, 0, 0, HOLD, PCM);
    chk("p3_count4", 64'(count), 64'(4));
    chk("p3_oerr0",  64'(order_err), 64'(0));
    tick();
    drive(0, 0, 0, 0, 0, HOLD, HOLD);
    chk("p3_first", 64'(first), 64'(0));
    chk("p3_count", 64'(count), 64'(3));
    chk_slots("p3", 32'hA1A1_0001, 16'h0021, 32'hA2A2_0002, 16'h0022);

    // 6b. older (slot0) held, younger (slot1) released -> order_err, no retire
    drive(0, 0, 0, 0, 0, HOLD, GO);
    chk("oerr_pulse", 64'(order_err), 64'(1));
    tick();
    drive(0, 0, 0, 0, 0, HOLD, HOLD);
    chk("oerr_count", 64'(count), 64'(3));
    chk("oerr_clear", 64'(order_err), 64'(0));
    chk_slots("oerr", 32'hA1A1_0001, 16'h0021, 32'hA2A2_0002, 16'h0022);

    // 6a. flush with a push and a would-be 2-retire
    drive(1, 32'hEEEE_0000, 32'hEEEE_0001, 16'h0050, 1, GO, GO);
    chk("flush_oerr", 64'(order_err), 64'(0));
    tick();
    drive(0, 0, 0, 0, 0, HOLD, HOLD);
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_v0v1",  64'({valid0, valid1}), 64'(2'b00));
    chk("flush_first", 64'(first), 64'(1));
    chk_slots("flush", 32'h0, 16'h0, 32'h0, 16'h0);

    // 4. fill to DEPTH, fifth push ignored
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'hB000_0000 + 32'(2 * k), 32'hB000_0001 + 32'(2 * k),
            16'h0040 + 16'(2 * k), 0, HOLD, HOLD);
      chk($sformatf("fill_ready%0d", k), 64'(fetch_ready), 64'(1));
      tick();
    end
    chk("full_count", 64'(count), 64'(8));
    chk("full_ready", 64'(fetch_ready), 64'(0));
    drive(1, 32'hCCCC_0000, 32'hCCCC_0001, 16'h0060, 0, HOLD, HOLD);
    tick();
    chk("full_5th_count", 64'(count), 64'(8));
    chk_slots("full", 32'hB000_0001, 16'h0041, 32'hB000_0000, 16'h0040);
    // release both with a push still offered: no room until the next cycle
    drive(1, 32'hCCCC_0000, 32'hCCCC_0001, 16'h0060, 0, GO, GO);
    chk("rel_ready_pre", 64'(fetch_ready), 64'(0));
    tick();
    drive(0, 0, 0, 0, 0, HOLD, HOLD);
    chk("rel_count", 64'(count), 64'(6));
    chk("rel_ready", 64'(fetch_ready), 64'(1));
    chk_slots("rel", 32'hB000_0003, 16'h0043, 32'hB000_0002, 16'h0042);

    // 5. wrap: drain to head=7 count=1, push pair at tail 0 -> head=7 tail=2 count=3
    drive(0, 0, 0, 0, 0, GO, GO);
    tick();
    tick();
    drive(0, 0, 0, 0, 0, HOLD, GO);
    chk("drain_count", 64'(count), 64'(2));
    tick();
    drive(1, 32'hD0D0_0000, 32'hD1D1_0001, 16'h0070, 0, HOLD, HOLD);
    chk("drain_count1", 64'(count), 64'(1));
    tick();
    drive(0, 0, 0, 0, 0, HOLD, HOLD);
    chk("wrap_count", 64'(count), 64'(3));
    chk("wrap_first", 64'(first), 64'(0));
    chk_slots("wrap", 32'hB000_0007, 16'h0047, 32'hD0D0_0000, 16'h0070);
    drive(0, 0, 0, 0, 0, GO, GO);
    tick();
    drive(0, 0, 0, 0, 0, HOLD, HOLD);
    chk("wrap_ret_count", 64'(count), 64'(1));
    chk("wrap_ret_first", 64'(first), 64'(0));
    chk("wrap_ret_v1", 64'(valid1), 64'(0));
    chk_slots("wrap_ret", 32'hD1D1_0001, 16'h0071, 32'h0, 16'h0);

    // mid-operation reset with a push offered, then fresh push lands at index 0
    reset = 1'b1;
    drive(1, 32'hEEEE_0000, 32'hEEEE_0001, 16'h0080, 0, GO, GO);
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, HOLD, HOLD);
    chk("mrst_count", 64'(count), 64'(0));
    chk("mrst_v0v1",  64'({valid0, valid1}), 64'(2'b00));
    chk("mrst_ready", 64'(fetch_ready), 64'(1));
    drive(1, 32'hF0F0_0000, 32'hF1F1_0001, 16'h0090, 0, HOLD, HOLD);
    tick();
    drive(0, 0, 0, 0, 0, HOLD, HOLD);
    chk("mrst_push_count", 64'(count), 64'(2));
    chk("mrst_push_first", 64'(first), 64'(1));
    chk_slots("mrst_push", 32'hF1F1_0001, 16'h0091, 32'hF0F0_0000, 16'h0090);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
